// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operand width, iteration count, op encodings, FSM states and
//               a signed-magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Operand/result width; the datapath only supports 32.
  localparam int XLEN  = 32;
  // One iteration per result bit.
  localparam int ITER  = 32;
  // Iteration counter width; must be able to hold ITER.
  localparam int CNT_W = 6;

  // Operation encodings driven on the op port.
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Magnitude of a two's-complement operand. For unsigned operations the raw
  // value is returned. The magnitude of INT_MIN is 0x80000000, which is the
  // correct unsigned magnitude, so no special case is needed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                               input logic            is_signed);
    abs_val = (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Iterative unsigned datapath shared by multiply and divide.
//               Multiply: 64-bit shift-add, {acc_hi, acc_lo} shifts right,
//               multiplicand added when acc_lo[0] is set.
//               Divide: restoring, remainder:quotient shifts left, divisor
//               subtracted whenever the 33-bit trial result is non-negative.
// Ports       : clk, resetn   - clock, asynchronous active-low reset
//               start         - load operands (mag_a, mag_b) for a new op
//               is_div        - 1 = divide, 0 = multiply
//               mag_a, mag_b  - unsigned operand magnitudes
//               step          - perform one iteration this cycle
//               product       - raw 64-bit product {acc_hi, acc_lo}
//               quot, rem     - raw quotient / remainder
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            is_div,
  input  logic [DW-1:0]   mag_a,
  input  logic [DW-1:0]   mag_b,
  input  logic            step,
  output logic [2*DW-1:0] product,
  output logic [DW-1:0]   quot,
  output logic [DW-1:0]   rem
);

  // acc_hi holds the product high half (multiply) or partial remainder
  // (divide); acc_lo holds multiplier bits / quotient bits; opnd holds the
  // multiplicand or the divisor.
  logic [DW-1:0] acc_hi_q, acc_hi_d;
  logic [DW-1:0] acc_lo_q, acc_lo_d;
  logic [DW-1:0] opnd_q,   opnd_d;

  logic [DW:0]   w_sum;    // acc_hi + multiplicand, with carry
  logic [DW:0]   w_shift;  // remainder shifted left with next dividend bit
  logic [DW:0]   w_diff;   // trial subtraction; bit DW is the borrow

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;

    w_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    w_shift = {acc_hi_q, acc_lo_q[DW-1]};
    w_diff  = w_shift - {1'b0, opnd_q};

    if (start) begin
      acc_hi_d = '0;
      if (is_div) begin
        acc_lo_d = mag_a;
        opnd_d   = mag_b;
      end else begin
        acc_lo_d = mag_b;
        opnd_d   = mag_a;
      end
    end else if (step) begin
      if (is_div) begin
        // The remainder is always below the divisor, so a successful
        // subtraction always fits back into DW bits.
        if (!w_diff[DW]) begin
          acc_hi_d = w_diff[DW-1:0];
          acc_lo_d = {acc_lo_q[DW-2:0], 1'b1};
        end else begin
          acc_hi_d = w_shift[DW-1:0];
          acc_lo_d = {acc_lo_q[DW-2:0], 1'b0};
        end
      end else begin
        // Shift the carry into the top of the accumulator.
        acc_hi_d = w_sum[DW:1];
        acc_lo_d = {w_sum[0], acc_lo_q[DW-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign product = {acc_hi_q, acc_lo_q};
  assign quot    = acc_lo_q;
  assign rem     = acc_hi_q;

endmodule : muldiv_core
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Sequencer for the iterative multiply/divide resource and owner
//               of the architectural HI/LO registers. Accepts MULT/MULTU/
//               DIV/DIVU and MTHI/MTLO from EX, runs 32 iterations plus a
//               sign-fix cycle, and stalls the front of the pipeline while a
//               HI/LO consumer or producer waits behind an operation.
// Ports       : clk, resetn          - clock, asynchronous active-low reset
//               op_valid, op         - mul/div instruction in EX and its kind
//               src_a, src_b         - rs / rt operands
//               mthi_we, mtlo_we     - MTHI / MTLO in EX
//               mt_data              - MTHI/MTLO write data
//               hi_used_id           - ID instruction reads HI
//               lo_used_id           - ID instruction reads LO
//               cancel               - abort in-flight operation
//               stall                - freeze IF/ID/EX (combinational)
//               busy                 - operation in flight
//               hi, lo               - architectural HI/LO
//               div_zero             - one-cycle divide-by-zero pulse
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] mt_data,
  input  logic            hi_used_id,
  input  logic            lo_used_id,
  input  logic            cancel,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(ITER - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              div_zero_q, div_zero_d;

  logic              w_op_div;
  logic              w_op_signed;
  logic              w_accept;
  logic              w_step;
  logic              w_core_div;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_product;
  logic [2*XLEN-1:0] w_product_fix;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  assign w_op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_mag_a     = abs_val(src_a, w_op_signed);
  assign w_mag_b     = abs_val(src_b, w_op_signed);

  // The core needs the op kind at load time (from the instruction) and
  // during iteration (from the latched flag).
  assign w_core_div  = (state_q == ST_IDLE) ? w_op_div : is_div_q;

  muldiv_core #(
    .DW (XLEN)
  ) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .start   (w_accept),
    .is_div  (w_core_div),
    .mag_a   (w_mag_a),
    .mag_b   (w_mag_b),
    .step    (w_step),
    .product (w_product),
    .quot    (w_quot),
    .rem     (w_rem)
  );

  assign w_product_fix = neg_res_q ? (~w_product + (2*XLEN)'(1)) : w_product;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    w_accept   = 1'b0;
    w_step     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          // A coincident MTHI/MTLO is illegal and dropped; a cancelled
          // instruction is simply not accepted.
          if (!cancel) begin
            if (w_op_div && (src_b == '0)) begin
              div_zero_d = 1'b1;
            end else begin
              w_accept  = 1'b1;
              state_d   = ST_RUN;
              cnt_d     = '0;
              is_div_d  = w_op_div;
              neg_res_d = w_op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
              neg_rem_d = w_op_signed & src_a[XLEN-1];
            end
          end
        end else begin
          if (mthi_we) hi_d = mt_data;
          if (mtlo_we) lo_d = mt_data;
        end
      end

      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          w_step = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == c_last_iter) state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          if (is_div_q) begin
            lo_d = neg_res_q ? (~w_quot + XLEN'(1)) : w_quot;
            hi_d = neg_rem_q ? (~w_rem  + XLEN'(1)) : w_rem;
          end else begin
            hi_d = w_product_fix[2*XLEN-1:XLEN];
            lo_d = w_product_fix[XLEN-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign stall    = busy & (hi_used_id | lo_used_id | op_valid | mthi_we | mtlo_we);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq. Expected HI/LO values come
//               from a plain-arithmetic model of the MIPS mult/div rules and a
//               bench-side copy of the architectural HI/LO state.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        mthi_we, mtlo_we;
  logic [31:0] mt_data;
  logic        hi_used_id, lo_used_id;
  logic        cancel;
  logic        stall, busy, div_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side architectural HI/LO.
  logic [31:0] ref_hi, ref_lo;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .mt_data    (mt_data),
    .hi_used_id (hi_used_id),
    .lo_used_id (lo_used_id),
    .cancel     (cancel),
    .stall      (stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the instruction-set definition using wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] f_op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f_op)
      2'd0:    model = 64'(sa * sb);
      2'd1:    model = ua * ub;
      2'd2:    begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      default: begin uq = ua / ub; ur = ua % ub; model = {ur[31:0], uq[31:0]}; end
    endcase
  endfunction

  // Issue one op, measure busy duration, compare the result.
  task automatic run_op(input string tag, input logic [1:0] t_op,
                        input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic [63:0] exp;
    exp      = model(t_op, a, b);
    op       = t_op;
    src_a    = a;
    src_b    = b;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(cyc), 32'd33);
    chk({tag, " hi"}, hi, exp[63:32]);
    chk({tag, " lo"}, lo, exp[31:0]);
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
  endtask

  initial begin
    int          cyc;
    logic [63:0] e1, e2;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    resetn = 1'b0; op_valid = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
    hi_used_id = 1'b0; lo_used_id = 1'b0; cancel = 1'b0;
    ref_hi = '0; ref_lo = '0;

    // ---- reset state
    #12;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset div_zero", div_zero, 1'b0);
    chk1("reset stall", stall, 1'b0);
    tick();
    resetn = 1'b1;
    tick();

    // ---- directed arithmetic
    run_op("mult -3*7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult -3*7 const hi", hi, 32'hFFFF_FFFF);
    chk("mult -3*7 const lo", lo, 32'hFFFF_FFEB);
    run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div -7/2 const lo", lo, 32'hFFFF_FFFD);
    chk("div -7/2 const hi", hi, 32'hFFFF_FFFF);
    run_op("divu big", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div intmin/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div intmin/-1 const lo", lo, 32'h8000_0000);
    chk("div intmin/-1 const hi", hi, 32'h0);

    // ---- divide by zero: pulse, no state change
    op = 2'd3; src_a = 32'd5; src_b = 32'd0; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk1("divz busy", busy, 1'b0);
    chk1("divz pulse", div_zero, 1'b1);
    tick();
    chk1("divz pulse end", div_zero, 1'b0);
    chk("divz hi", hi, ref_hi);
    chk("divz lo", lo, ref_lo);

    // ---- MULTU with an MFHI waiting in ID
    e1 = model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op = 2'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    hi_used_id = 1'b1;
    #1;
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("mfhi stall_cycles", 32'(cyc), 32'd33);
    chk1("mfhi stall released", stall, 1'b0);
    chk("mfhi hi", hi, 32'hFFFF_FFFE);
    chk("mfhi lo", lo, 32'h0000_0001);
    ref_hi = e1[63:32]; ref_lo = e1[31:0];
    hi_used_id = 1'b0;

    // ---- back-to-back: DIVU presented while MULT busy
    e1 = model(2'd0, 32'd1234567, 32'hFFFF_0001);
    e2 = model(2'd3, 32'hDEAD_BEEF, 32'd1000);
    op = 2'd0; src_a = 32'd1234567; src_b = 32'hFFFF_0001; op_valid = 1'b1;
    tick();
    op = 2'd3; src_a = 32'hDEAD_BEEF; src_b = 32'd1000;
    #1;
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("b2b stall_cycles", 32'(cyc), 32'd33);
    chk("b2b first hi", hi, e1[63:32]);
    chk("b2b first lo", lo, e1[31:0]);
    tick();
    op_valid = 1'b0;
    chk1("b2b second accepted", busy, 1'b1);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("b2b second busy_cycles", 32'(cyc), 32'd33);
    chk("b2b second hi", hi, e2[63:32]);
    chk("b2b second lo", lo, e2[31:0]);
    ref_hi = e2[63:32]; ref_lo = e2[31:0];

    // ---- MTLO held back while an op is in flight
    e1 = model(2'd0, 32'h0001_0003, 32'h0000_0100);
    op = 2'd0; src_a = 32'h0001_0003; src_b = 32'h0000_0100; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    mtlo_we = 1'b1; mt_data = 32'h0000_1234;
    #1;
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("mtlo stall_cycles", 32'(cyc), 32'd33);
    chk("mtlo not early", lo, e1[31:0]);
    tick();
    mtlo_we = 1'b0;
    chk("mtlo lo", lo, 32'h0000_1234);
    chk("mtlo hi kept", hi, e1[63:32]);
    ref_hi = e1[63:32]; ref_lo = 32'h0000_1234;

    // ---- MTHI+MTLO together in IDLE
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hCAFE_F00D;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt both hi", hi, 32'hCAFE_F00D);
    chk("mt both lo", lo, 32'hCAFE_F00D);
    ref_hi = 32'hCAFE_F00D; ref_lo = 32'hCAFE_F00D;

    // ---- op_valid with MTHI: op wins, MT dropped
    mthi_we = 1'b1; mt_data = 32'h0000_DEAD;
    run_op("op+mthi", 2'd0, 32'd2, 32'd3);
    mthi_we = 1'b0;

    // ---- randomized ops against the model
    for (int i = 0; i < 12; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 4 == 1) r_b = 32'($urandom_range(1, 17));
      if (i % 4 == 2) r_a = {1'b1, r_a[30:0]};
      if (r_op[1] && r_b == 32'd0) r_b = 32'd1;
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b);
    end

    // ---- cancel in RUN: HI/LO untouched
    op = 2'd2; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk1("cancel busy", busy, 1'b0);
    repeat (30) tick();
    chk("cancel hi", hi, ref_hi);
    chk("cancel lo", lo, ref_lo);

    // ---- cancel in IDLE blocks a coincident op
    op = 2'd1; src_a = 32'd3; src_b = 32'd3; op_valid = 1'b1; cancel = 1'b1;
    tick();
    op_valid = 1'b0; cancel = 1'b0;
    chk1("idle cancel busy", busy, 1'b0);

    // ---- reset mid-operation clears HI/LO
    op = 2'd1; src_a = 32'd9; src_b = 32'd9; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    #1;
    chk1("midreset busy", busy, 1'b0);
    chk("midreset hi", hi, 32'h0);
    chk("midreset lo", lo, 32'h0);
    ref_hi = '0; ref_lo = '0;
    tick();
    resetn = 1'b1;
    tick();
    run_op("after reset", 2'd0, 32'hFFFF_FF00, 32'hFFFF_FF00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_muldiv_seq
`default_nettype wire
